// File: rtl/slow_to_fast_serializer_if.sv
// Bundle between the slow-word source, fast-lane sink and serializer:
// phase count and wide word in, narrow lanes and lock status out.
interface slow_to_fast_serializer_if #(
   parameter int RATIO  = 4,
   parameter int DWIDTH = 32
);
   localparam int CW = $clog2(RATIO);

   logic [CW-1:0]           cnt;
   logic [RATIO*DWIDTH-1:0] slow_data;
   logic                    slow_valid;
   logic [DWIDTH-1:0]       fast_data;
   logic                    fast_valid;
   logic                    fast_last;
   logic                    locked;
   logic [7:0]              slip_cnt;

   modport master (
      output cnt, slow_data, slow_valid,
      input  fast_data, fast_valid, fast_last, locked, slip_cnt
   );

   modport slave (
      input  cnt, slow_data, slow_valid,
      output fast_data, fast_valid, fast_last, locked, slip_cnt
   );
endinterface

// File: rtl/slow_to_fast_serializer.sv
// Splits a clk_slow word into RATIO clk_fast lanes, LSB lane first,
// emitting only while the phase count has been seen continuous.
module slow_to_fast_serializer #(
   parameter int RATIO     = 4,
   parameter int DWIDTH    = 32,
   parameter int CAP_PHASE = 1,
   parameter int LOCK_CNT  = 8
) (
   input  logic                     clk_fast,
   input  logic                     rst_n,
   slow_to_fast_serializer_if.slave bus
);
   localparam int CW = $clog2(RATIO);
   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam logic [CW-1:0] LAST_PH = CW'(RATIO - 1);
   localparam logic [CW-1:0] CAP     = CW'(CAP_PHASE);
   localparam logic [GW-1:0] GOAL    = GW'(LOCK_CNT);

   typedef enum logic {ALIGN, LOCKED} state_t;
   state_t state_q, state_d;

   logic [CW-1:0]     cnt_prev_q;
   logic [CW-1:0]     exp_cnt;
   logic              prev_ok_q;
   logic [GW-1:0]     good_q, good_d;
   logic [CW-1:0]     lane_q, lane_d;
   logic [DWIDTH-1:0] word_q [RATIO];
   logic [DWIDTH-1:0] word_d [RATIO];
   logic [DWIDTH-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic [7:0]        slip_q, slip_d;
   logic              step_good, step_bad, capture;

   assign exp_cnt   = (cnt_prev_q == LAST_PH) ? '0 : cnt_prev_q + CW'(1);
   assign step_good = prev_ok_q && (bus.cnt == exp_cnt);
   assign step_bad  = prev_ok_q && !step_good;

   // Lock tracking, lane sequencing and next-state selection
   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      lane_d  = lane_q;
      word_d  = word_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      slip_d  = slip_q;
      capture = 1'b0;
      unique case (state_q)
         ALIGN: begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            if (step_bad)
               good_d = '0;
            else if (step_good && good_q != GOAL)
               good_d = good_q + GW'(1);
            if (step_good && good_q == GOAL && bus.cnt == CAP) begin
               state_d = LOCKED;
               capture = 1'b1;
            end
         end
         LOCKED: begin
            if (step_bad) begin
               state_d = ALIGN;
               valid_d = 1'b0;
               last_d  = 1'b0;
               good_d  = '0;
               if (slip_q != 8'hFF)
                  slip_d = slip_q + 8'd1;
            end else if (bus.cnt == CAP) begin
               capture = 1'b1;
            end else begin
               data_d = word_q[lane_q];
               lane_d = lane_q + CW'(1);
               last_d = valid_q && (lane_q == LAST_PH);
            end
         end
      endcase
      if (capture) begin
         for (int i = 0; i < RATIO; i++)
            word_d[i] = bus.slow_data[i*DWIDTH +: DWIDTH];
         data_d  = bus.slow_data[DWIDTH-1:0];
         valid_d = bus.slow_valid;
         last_d  = 1'b0;
         lane_d  = CW'(1);
      end
   end

   // FSM state register
   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n)
         state_q <= ALIGN;
      else
         state_q <= state_d;
   end

   // Phase history, word buffer and output registers
   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         cnt_prev_q <= '0;
         prev_ok_q  <= 1'b0;
         good_q     <= '0;
         lane_q     <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         slip_q     <= '0;
         for (int i = 0; i < RATIO; i++)
            word_q[i] <= '0;
      end else begin
         cnt_prev_q <= bus.cnt;
         prev_ok_q  <= 1'b1;
         good_q     <= good_d;
         lane_q     <= lane_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         last_q     <= last_d;
         slip_q     <= slip_d;
         word_q     <= word_d;
      end
   end

   assign bus.fast_data  = data_q;
   assign bus.fast_valid = valid_q;
   assign bus.fast_last  = last_q;
   assign bus.locked     = (state_q == LOCKED);
   assign bus.slip_cnt   = slip_q;
endmodule

// File: tb/tb_slow_to_fast_serializer.sv
// Bench for slow_to_fast_serializer: main instance RATIO=4/CAP=1 plus
// RATIO=3/CAP=2 and RATIO=8/CAP=7 instances, against a lane-queue model.
module tb_slow_to_fast_serializer;
   localparam int LOCK = 8;

   logic clk = 1'b0;
   logic rst0 = 1'b0;
   logic rst1 = 1'b0;
   always #5 clk = ~clk;

   int          cc [3];
   logic [63:0] cd [3];
   bit          cv [3];

   slow_to_fast_serializer_if #(.RATIO(4), .DWIDTH(8)) if0 ();
   slow_to_fast_serializer_if #(.RATIO(3), .DWIDTH(8)) if1 ();
   slow_to_fast_serializer_if #(.RATIO(8), .DWIDTH(8)) if2 ();

   assign if0.cnt = cc[0][1:0];
   assign if1.cnt = cc[1][1:0];
   assign if2.cnt = cc[2][2:0];
   assign if0.slow_data = cd[0][31:0];
   assign if1.slow_data = cd[1][23:0];
   assign if2.slow_data = cd[2];
   assign if0.slow_valid = cv[0];
   assign if1.slow_valid = cv[1];
   assign if2.slow_valid = cv[2];

   slow_to_fast_serializer #(.RATIO(4), .DWIDTH(8), .CAP_PHASE(1), .LOCK_CNT(LOCK))
      u0 (.clk_fast(clk), .rst_n(rst0), .bus(if0));
   slow_to_fast_serializer #(.RATIO(3), .DWIDTH(8), .CAP_PHASE(2), .LOCK_CNT(LOCK))
      u1 (.clk_fast(clk), .rst_n(rst1), .bus(if1));
   slow_to_fast_serializer #(.RATIO(8), .DWIDTH(8), .CAP_PHASE(7), .LOCK_CNT(LOCK))
      u2 (.clk_fast(clk), .rst_n(rst1), .bus(if2));

   int checks = 0;
   int errors = 0;
   int nl2 = 0;

   function automatic int rat(input int id);
      return (id == 0) ? 4 : ((id == 1) ? 3 : 8);
   endfunction

   function automatic int cap(input int id);
      return (id == 0) ? 1 : ((id == 1) ? 2 : 7);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, want, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {logic [7:0] d; logic v; logic l;} lane_t;
   bit         m_pv [3];
   int         m_prev [3];
   int         m_run [3];
   int         m_slip [3];
   bit         m_lk [3];
   logic [7:0] m_hold [3];
   bit         m_hk [3];
   lane_t      pend [3][8];
   int         pn [3];
   int         pi [3];
   bit         e_v [3];
   bit         e_l [3];

   task automatic model_reset(input int id);
      m_pv[id] = 0; m_prev[id] = 0; m_run[id] = 0; m_slip[id] = 0;
      m_lk[id] = 0; m_hold[id] = 8'h00; m_hk[id] = 1; pn[id] = 0; pi[id] = 0;
      e_v[id] = 0; e_l[id] = 0;
   endtask

   task automatic model_edge(input int id, input int c, input logic [63:0] d, input bit v);
      bit good, bad;
      int r;
      r = rat(id);
      good = m_pv[id] && (c == (m_prev[id] + 1) % r);
      bad = m_pv[id] && !good;
      m_pv[id] = 1;
      m_prev[id] = c;
      e_v[id] = 0;
      e_l[id] = 0;
      if (m_lk[id] && bad) begin
         m_lk[id] = 0; m_run[id] = 0; pn[id] = 0; pi[id] = 0;
         if (m_slip[id] < 255) m_slip[id]++;
      end else if (!m_lk[id]) begin
         if (good && m_run[id] >= LOCK && c == cap(id)) m_lk[id] = 1;
         else if (bad) m_run[id] = 0;
         else if (good && m_run[id] < LOCK) m_run[id]++;
      end
      if (m_lk[id]) begin
         if (c == cap(id)) begin
            for (int k = 0; k < r; k++)
               pend[id][k] = '{d: d[8*k +: 8], v: v, l: v && (k == r - 1)};
            pn[id] = r;
            pi[id] = 0;
         end
         if (pi[id] < pn[id]) begin
            e_v[id] = pend[id][pi[id]].v;
            e_l[id] = pend[id][pi[id]].l;
            m_hold[id] = pend[id][pi[id]].d;
            m_hk[id] = pend[id][pi[id]].v;
            pi[id]++;
         end
      end
   endtask

   task automatic get_out(input int id, output logic [7:0] d, output logic v,
                          output logic l, output logic k, output logic [7:0] s);
      case (id)
         0: begin d = if0.fast_data; v = if0.fast_valid; l = if0.fast_last;
                  k = if0.locked; s = if0.slip_cnt; end
         1: begin d = if1.fast_data; v = if1.fast_valid; l = if1.fast_last;
                  k = if1.locked; s = if1.slip_cnt; end
         default: begin d = if2.fast_data; v = if2.fast_valid; l = if2.fast_last;
                  k = if2.locked; s = if2.slip_cnt; end
      endcase
   endtask

   // one clk_fast cycle: edge, model, compare, advance the sweep instances
   task automatic cyc();
      logic [7:0] d, s;
      logic v, l, k;
      @(posedge clk);
      for (int id = 0; id < 3; id++) model_edge(id, cc[id], cd[id], cv[id]);
      #1;
      for (int id = 0; id < 3; id++) begin
         get_out(id, d, v, l, k, s);
         chk($sformatf("m%0d_locked", id), k, m_lk[id]);
         chk($sformatf("m%0d_valid", id), v, e_v[id]);
         chk($sformatf("m%0d_last", id), l, e_l[id]);
         chk($sformatf("m%0d_slip", id), s, m_slip[id]);
         if (m_hk[id]) chk($sformatf("m%0d_data", id), d, m_hold[id]);
         if (id == 2 && l === 1'b1) nl2++;
      end
      for (int id = 1; id < 3; id++) begin
         cc[id] = (cc[id] + 1) % rat(id);
         if (cc[id] == 0) begin
            cd[id] = {$urandom, $urandom};
            cv[id] = ($urandom_range(3) != 0);
         end
      end
   endtask

   task automatic wait_lock(output int n);
      n = 0;
      while (if0.locked !== 1'b1 && n < 40) begin
         cc[0] = (cc[0] + 1) % 4;
         cyc();
         n++;
      end
      chk("lock_wait", if0.locked, 1'b1);
   endtask

   typedef struct {
      int c; logic [31:0] d; bit v;
      logic [7:0] ed; bit ev; bit el; bit elk;
   } vec_t;
   vec_t tbl [17];

   function automatic vec_t mk(input int c, input logic [31:0] d, input bit v,
                               input logic [7:0] ed, input bit ev, input bit el, input bit elk);
      vec_t t;
      t.c = c; t.d = d; t.v = v; t.ed = ed; t.ev = ev; t.el = el; t.elk = elk;
      return t;
   endfunction

   initial begin
      logic [31:0] words [3];
      logic [31:0] got1, got3;
      int inv, lk, n;

      for (int i = 0; i < 9; i++) tbl[i] = mk(i % 4, 32'hDDCCBBAA, 1, 8'h00, 0, 0, 0);
      tbl[9]  = mk(1, 32'hDDCCBBAA, 1, 8'hAA, 1, 0, 1);
      tbl[10] = mk(2, 32'hDDCCBBAA, 1, 8'hBB, 1, 0, 1);
      tbl[11] = mk(3, 32'hDDCCBBAA, 1, 8'hCC, 1, 0, 1);
      tbl[12] = mk(0, 32'h44332211, 1, 8'hDD, 1, 1, 1);
      tbl[13] = mk(1, 32'h44332211, 1, 8'h11, 1, 0, 1);
      tbl[14] = mk(2, 32'h44332211, 1, 8'h22, 1, 0, 1);
      tbl[15] = mk(3, 32'h44332211, 1, 8'h33, 1, 0, 1);
      tbl[16] = mk(0, 32'h55667788, 1, 8'h44, 1, 1, 1);

      for (int id = 0; id < 3; id++) begin
         cc[id] = 0; cd[id] = {$urandom, $urandom}; cv[id] = 1;
         model_reset(id);
      end

      #2;
      chk("rst_data", if0.fast_data, 8'h00);
      chk("rst_valid", if0.fast_valid, 1'b0);
      chk("rst_last", if0.fast_last, 1'b0);
      chk("rst_locked", if0.locked, 1'b0);
      chk("rst_slip", if0.slip_cnt, 8'h00);
      #10;
      rst0 = 1'b1;
      rst1 = 1'b1;

      // T1/T2: lock from free-running cnt, then serialize two words
      for (int i = 0; i < 17; i++) begin
         cc[0] = tbl[i].c; cd[0] = {32'h0, tbl[i].d}; cv[0] = tbl[i].v;
         cyc();
         chk($sformatf("tbl%0d_data", i), if0.fast_data, tbl[i].ed);
         chk($sformatf("tbl%0d_valid", i), if0.fast_valid, tbl[i].ev);
         chk($sformatf("tbl%0d_last", i), if0.fast_last, tbl[i].el);
         chk($sformatf("tbl%0d_locked", i), if0.locked, tbl[i].elk);
      end

      // T3: invalid word between two valid words
      words[0] = 32'hA1B2C3D4; words[1] = 32'h01020304; words[2] = 32'h0F1E2D3C;
      inv = 0; lk = 0; got1 = '0; got3 = '0;
      for (int w = 0; w < 3; w++) begin
         for (int k = 0; k < 4; k++) begin
            cc[0] = (1 + k) % 4;
            if (k == 0) begin cd[0] = {32'h0, words[w]}; cv[0] = (w != 1); end
            cyc();
            if (if0.fast_valid !== 1'b1) inv++;
            if (if0.locked === 1'b1) lk++;
            if (w == 0) got1[8*k +: 8] = if0.fast_data;
            if (w == 2) got3[8*k +: 8] = if0.fast_data;
         end
      end
      chk("t3_gap", inv, 4);
      chk("t3_locked", lk, 12);
      chk("t3_word1", got1, 32'hA1B2C3D4);
      chk("t3_word3", got3, 32'h0F1E2D3C);

      // T4: slip mid-word and relock
      cc[0] = 1; cd[0] = {32'h0, 32'h55667788}; cv[0] = 1;
      cyc();
      cc[0] = 3;
      cyc();
      chk("t4_locked", if0.locked, 1'b0);
      chk("t4_valid", if0.fast_valid, 1'b0);
      chk("t4_slip", if0.slip_cnt, 8'd1);
      cd[0] = {32'h0, 32'h99AABBCC};
      wait_lock(n);
      chk("t4_relock_cycles", n, 10);
      chk("t4_lane0", if0.fast_data, 8'hCC);
      chk("t4_lane0_valid", if0.fast_valid, 1'b1);
      for (int k = 1; k < 4; k++) begin
         cc[0] = (cc[0] + 1) % 4;
         cyc();
         chk($sformatf("t4_lane%0d", k), if0.fast_data, (k == 1) ? 8'hBB : ((k == 2) ? 8'hAA : 8'h99));
         chk($sformatf("t4_last%0d", k), if0.fast_last, k == 3);
      end

      // T5: slip counter saturation
      for (int s = 0; s < 300; s++) begin
         wait_lock(n);
         cc[0] = (cc[0] + 2) % 4;
         cyc();
      end
      chk("t5_slip_sat", if0.slip_cnt, 8'd255);

      // T5: asynchronous reset mid-word
      wait_lock(n);
      cc[0] = (cc[0] + 1) % 4;
      cyc();
      #2 rst0 = 1'b0;
      #1;
      chk("t5_rst_data", if0.fast_data, 8'h00);
      chk("t5_rst_valid", if0.fast_valid, 1'b0);
      chk("t5_rst_last", if0.fast_last, 1'b0);
      chk("t5_rst_locked", if0.locked, 1'b0);
      chk("t5_rst_slip", if0.slip_cnt, 8'h00);
      #2 rst0 = 1'b1;
      model_reset(0);
      wait_lock(n);

      // randomized phase jumps and words against the model
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(29) == 0) cc[0] = $urandom_range(3);
         else cc[0] = (cc[0] + 1) % 4;
         if (cc[0] == 0) begin
            cd[0] = {32'h0, $urandom};
            cv[0] = ($urandom_range(3) != 0);
         end
         cyc();
      end

      // T6: the sweep instances ran continuously alongside
      chk("t6_r3_locked", if1.locked, 1'b1);
      chk("t6_r8_locked", if2.locked, 1'b1);
      chk("t6_r8_last_seen", nl2 > 0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
